rock_scheduler: RTL and testbench
=================================

Name: rock_scheduler

Overview:
- Sequences the frequency/amplitude step unit of the rocking controller.
- Turns the cry-detector level and the manual up/down buttons into single-cycle step commands (freq_up, freq_down, amp_down).
- Enforces a settle time after every command.
- Guards the 3-bit F counter against wrap, ramps the rocking down once the baby stays calm, and latches a fault on a step-unit error.

Parameters:
- SETTLE_CYCLES, 16, cycles held in WAIT after any issued command (1..255).
- CALM_CYCLES, 64, consecutive cry-free cycles in ROCK before one auto ramp-down step (1..255).
- FMAX, 7, highest F value the scheduler will step up to.

Ports:
- clk  in  1  system clock; all state and outputs update on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; begin a rocking session from IDLE.
- stop  in  1  level; abort the session from any state.
- cry  in  1  cry-detector level, synchronous to clk.
- btn_up  in  1  manual frequency-up button, already debounced.
- btn_down  in  1  manual frequency-down button, already debounced.
- f_val  in  3  current F from the step unit.
- a_val  in  3  current A from the step unit.
- step_err  in  1  error flag from the step unit.
- freq_up  out  1  one-cycle command: F+1.
- freq_down  out  1  one-cycle command: F-1.
- amp_down  out  1  one-cycle command: A-1.
- busy  out  1  high in every state except IDLE, DONE and FAULT.
- done  out  1  high in DONE.
- fault  out  1  high in FAULT.
- state  out  3  encoding IDLE=0, ROCK=1, WAIT=2, DONE=3, FAULT=4.

Behaviour:
- Reset: state=IDLE; all outputs 0; timers and button edge registers cleared. Reset in mid-session or mid-WAIT aborts with no further pulse.
- Commands:
  - Registered; exactly one cycle wide.
  - At most one command high in any cycle.
  - Every command is followed by WAIT.
- Button handling:
  - Rising-edge detected: one command per press, held level ignored.
  - Edges are captured only in ROCK; edges arriving in other states are discarded, not queued.
- IDLE:
  - start=1 -> ROCK.
  - calm counter cleared.
- ROCK, evaluated in this priority order each cycle:
  1. stop=1 -> IDLE, no command.
  2. btn_up edge and btn_down edge in the same cycle -> both ignored, stay ROCK.
  3. btn_up edge:
     - f_val<FMAX -> freq_up, go to WAIT.
     - Otherwise ignored.
  4. btn_down edge:
     - f_val>1 -> freq_down, go to WAIT.
     - Otherwise ignored.
  5. Manual requests beat auto in the same cycle.
  6. cry=1:
     - Calm counter cleared.
     - f_val<FMAX -> freq_up, go to WAIT.
     - f_val=FMAX -> no command, stay ROCK.
  7. cry=0:
     - Calm counter increments.
     - Counter reaching CALM_CYCLES clears it and fires the auto ramp-down:
       - f_val>1 -> freq_down.
       - Else if a_val!=0 -> amp_down.
       - Else -> DONE, no command.
     - When a command is issued -> WAIT.
- WAIT:
  - Settle timer loads SETTLE_CYCLES on entry; returns to ROCK after exactly SETTLE_CYCLES cycles.
  - cry is ignored and the calm counter is held.
  - stop=1 -> IDLE immediately.
  - step_err=1 in any WAIT cycle -> FAULT.
- DONE:
  - done=1.
  - start=1 -> ROCK with a fresh calm count.
  - stop=1 -> IDLE.
- FAULT:
  - fault=1; sticky, no commands.
  - Left only by stop=1 (-> IDLE) or reset.
- Guards:
  - freq_up is never issued at f_val=FMAX (prevents 7->0 wrap).
  - freq_down is never issued at f_val<=1 (F=0 triggers the step unit's automatic amplitude drain).
  - amp_down is never issued at a_val=0.
- Timers:
  - 8-bit calm counter and 8-bit settle counter.
  - A saturating compare is sufficient; no wrap within the legal parameter range.
- Latency: input sampled in ROCK -> command asserted on the next rising edge -> state=WAIT in that same cycle.

Test Plan:
- Session with cry: reset; start; f_val=4; hold cry=1 -> freq_up one cycle, then 16 cycles in WAIT, then freq_up again; at f_val=7, cry=1 gives no pulse and state stays ROCK.
- Calm ramp-down: f_val=2, a_val=1, cry=0:
  - After 64 ROCK cycles -> freq_down.
  - Then, with f_val=1, after a WAIT plus 64 further ROCK cycles -> amp_down.
  - Then, with a_val=0, after a WAIT plus 64 further ROCK cycles -> done=1, state=3.
- Manual arbitration:
  - btn_up edge together with cry=0 at count 63 -> freq_up only, calm counter held.
  - btn_up and btn_down edges in the same cycle -> no pulse.
  - btn_up held for 40 cycles -> exactly one pulse.
- Fault: step_err=1 in the third WAIT cycle -> fault=1, state=4, no commands for 100 cycles even with cry=1; stop=1 -> IDLE.
- Abort: stop=1 during WAIT -> IDLE next cycle with busy=0; an async reset mid-ROCK clears all outputs immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rock_scheduler.sv
// rock_scheduler: sequences the F/A step unit of the rocking controller.
// Converts cry level and manual button presses into one-cycle step commands,
// enforces a settle time after each command, guards F against wrap, ramps
// down after a sustained calm period and latches a fault on step-unit error.
module rock_scheduler #(
    parameter int SETTLE_CYCLES = 16,
    parameter int CALM_CYCLES   = 64,
    parameter int FMAX          = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       cry,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [2:0] f_val,
    input  logic [2:0] a_val,
    input  logic       step_err,
    output logic       freq_up,
    output logic       freq_down,
    output logic       amp_down,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ROCK  = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);
    localparam logic [7:0] CALM_LIM  = 8'(CALM_CYCLES);
    localparam logic [2:0] FMAX_V    = 3'(FMAX);

    // Calm counter never wraps: it sticks at its top value.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] calm_q, calm_d;
    logic [7:0] settle_q, settle_d;
    logic       up_prev_q, dn_prev_q;
    logic       freq_up_q, freq_up_d;
    logic       freq_down_q, freq_down_d;
    logic       amp_down_q, amp_down_d;

    logic       up_edge, dn_edge;
    logic [7:0] calm_inc;

    // Previous-level registers track the buttons in every state, so a level
    // held across WAIT never looks like a fresh press when ROCK resumes.
    assign up_edge  = btn_up & ~up_prev_q;
    assign dn_edge  = btn_down & ~dn_prev_q;
    assign calm_inc = sat_inc8(calm_q);

    // State, timers, edge history and registered command pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            calm_q      <= 8'd0;
            settle_q    <= 8'd0;
            up_prev_q   <= 1'b0;
            dn_prev_q   <= 1'b0;
            freq_up_q   <= 1'b0;
            freq_down_q <= 1'b0;
            amp_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            calm_q      <= calm_d;
            settle_q    <= settle_d;
            up_prev_q   <= btn_up;
            dn_prev_q   <= btn_down;
            freq_up_q   <= freq_up_d;
            freq_down_q <= freq_down_d;
            amp_down_q  <= amp_down_d;
        end
    end

    // Next-state, timer and command decode; any issued command moves to WAIT.
    always_comb begin
        state_d     = state_q;
        calm_d      = calm_q;
        settle_d    = settle_q;
        freq_up_d   = 1'b0;
        freq_down_d = 1'b0;
        amp_down_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                calm_d = 8'd0;
                if (!stop && start) state_d = S_ROCK;
            end
            S_ROCK: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (up_edge && dn_edge) begin
                    // Conflicting presses cancel; calm count is held this cycle.
                    state_d = S_ROCK;
                end else if (up_edge && (f_val < FMAX_V)) begin
                    freq_up_d = 1'b1;
                    state_d   = S_WAIT;
                    settle_d  = SETTLE_LD;
                end else if (dn_edge && (f_val > 3'd1)) begin
                    freq_down_d = 1'b1;
                    state_d     = S_WAIT;
                    settle_d    = SETTLE_LD;
                end else if (cry) begin
                    calm_d = 8'd0;
                    if (f_val < FMAX_V) begin
                        freq_up_d = 1'b1;
                        state_d   = S_WAIT;
                        settle_d  = SETTLE_LD;
                    end
                end else if (calm_inc >= CALM_LIM) begin
                    calm_d = 8'd0;
                    if (f_val > 3'd1) begin
                        freq_down_d = 1'b1;
                        state_d     = S_WAIT;
                        settle_d    = SETTLE_LD;
                    end else if (a_val != 3'd0) begin
                        amp_down_d = 1'b1;
                        state_d    = S_WAIT;
                        settle_d   = SETTLE_LD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    calm_d = calm_inc;
                end
            end
            S_WAIT: begin
                if (stop)                   state_d = S_IDLE;
                else if (step_err)          state_d = S_FAULT;
                else if (settle_q <= 8'd1)  state_d = S_ROCK;
                else                        settle_d = settle_q - 8'd1;
            end
            S_DONE: begin
                calm_d = 8'd0;
                if (stop)       state_d = S_IDLE;
                else if (start) state_d = S_ROCK;
            end
            S_FAULT: begin
                if (stop) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign freq_up   = freq_up_q;
    assign freq_down = freq_down_q;
    assign amp_down  = amp_down_q;
    assign state     = state_q;
    assign busy      = (state_q == S_ROCK) || (state_q == S_WAIT);
    assign done      = (state_q == S_DONE);
    assign fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_rock_scheduler.sv
// Directed bench for rock_scheduler: expected observations are queued as each
// cycle's stimulus is driven and compared when the DUT updates after the edge.
module tb_rock_scheduler;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ROCK  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] FAULT = 3'd4;
    localparam logic [2:0] NONE  = 3'b000;
    localparam logic [2:0] FU    = 3'b100;
    localparam logic [2:0] FD    = 3'b010;
    localparam logic [2:0] AD    = 3'b001;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, cry, btn_up, btn_down, step_err;
    logic [2:0] f_val, a_val;
    logic       freq_up, freq_down, amp_down, busy, done, fault;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] sb_q[$];
    string      tag_q[$];

    rock_scheduler dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .cry      (cry),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .f_val    (f_val),
        .a_val    (a_val),
        .step_err (step_err),
        .freq_up  (freq_up),
        .freq_down(freq_down),
        .amp_down (amp_down),
        .busy     (busy),
        .done     (done),
        .fault    (fault),
        .state    (state)
    );

    always #5 clk = ~clk;

    wire [8:0] obs = {state, freq_up, freq_down, amp_down, busy, done, fault};

    function automatic logic [8:0] exp_obs(input logic [2:0] st, input logic [2:0] cmd);
        logic b, d, f;
        b = (st == ROCK) || (st == WAIT);
        d = (st == DONE);
        f = (st == FAULT);
        return {st, cmd, b, d, f};
    endfunction

    task automatic check(input logic [8:0] got, input logic [8:0] exp, input string tag);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // One clock: queue the expectation for this cycle, then compare after the edge.
    task automatic cyc(input logic [8:0] exp, input string tag);
        logic [8:0] e;
        string      t;
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check(obs, e, t);
    endtask

    // Remaining 15 settle cycles after the pulse cycle, then the return to ROCK.
    task automatic wait_out(input string tag);
        for (int i = 0; i < 15; i++) cyc(exp_obs(WAIT, NONE), tag);
        cyc(exp_obs(ROCK, NONE), tag);
    endtask

    task automatic rock_quiet(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(exp_obs(ROCK, NONE), tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; cry = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; step_err = 1'b0;
        f_val = 3'd0; a_val = 3'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check(obs, exp_obs(IDLE, NONE), "reset_state");
        reset = 1'b0;

        // Session with cry
        f_val = 3'd4; a_val = 3'd3; cry = 1'b1; start = 1'b1;
        cyc(exp_obs(ROCK, NONE), "start_rock");
        start = 1'b0;
        cyc(exp_obs(WAIT, FU), "cry_up1");
        f_val = 3'd5;
        wait_out("settle1");
        cyc(exp_obs(WAIT, FU), "cry_up2");
        f_val = 3'd7;
        wait_out("settle2");
        for (int i = 0; i < 3; i++) cyc(exp_obs(ROCK, NONE), "cry_at_fmax");

        // Calm ramp-down
        cry = 1'b0; f_val = 3'd2; a_val = 3'd1;
        rock_quiet(63, "calm_count1");
        cyc(exp_obs(WAIT, FD), "calm_fd");
        f_val = 3'd1;
        wait_out("settle3");
        rock_quiet(63, "calm_count2");
        cyc(exp_obs(WAIT, AD), "calm_ad");
        a_val = 3'd0;
        wait_out("settle4");
        rock_quiet(63, "calm_count3");
        cyc(exp_obs(DONE, NONE), "calm_done");
        cyc(exp_obs(DONE, NONE), "done_hold");

        // Manual arbitration
        start = 1'b1; f_val = 3'd3; a_val = 3'd2;
        cyc(exp_obs(ROCK, NONE), "restart");
        start = 1'b0;
        rock_quiet(63, "calm_to_63");
        btn_up = 1'b1;
        cyc(exp_obs(WAIT, FU), "man_beats_auto");
        btn_up = 1'b0; f_val = 3'd4;
        wait_out("settle5");
        cyc(exp_obs(WAIT, FD), "calm_held");
        wait_out("settle6");
        btn_up = 1'b1; btn_down = 1'b1;
        cyc(exp_obs(ROCK, NONE), "both_edges");
        btn_up = 1'b0; btn_down = 1'b0;
        cyc(exp_obs(ROCK, NONE), "both_release");
        btn_up = 1'b1;
        cyc(exp_obs(WAIT, FU), "hold_up_pulse");
        wait_out("hold_up_wait");
        rock_quiet(23, "hold_up_no_repeat");
        btn_up = 1'b0; btn_down = 1'b1;
        cyc(exp_obs(WAIT, FD), "man_down");
        btn_down = 1'b0;
        wait_out("settle7");
        f_val = 3'd1; btn_down = 1'b1;
        cyc(exp_obs(ROCK, NONE), "down_guard_f1");
        btn_down = 1'b0; f_val = 3'd7; btn_up = 1'b1;
        cyc(exp_obs(ROCK, NONE), "up_guard_fmax");
        btn_up = 1'b0;

        // Fault
        f_val = 3'd4; cry = 1'b1;
        cyc(exp_obs(WAIT, FU), "fault_pre_pulse");
        cyc(exp_obs(WAIT, NONE), "fault_wait2");
        step_err = 1'b1;
        cyc(exp_obs(FAULT, NONE), "fault_enter");
        step_err = 1'b0;
        for (int i = 0; i < 100; i++) cyc(exp_obs(FAULT, NONE), "fault_sticky");
        stop = 1'b1;
        cyc(exp_obs(IDLE, NONE), "fault_stop");
        stop = 1'b0;

        // Abort
        start = 1'b1; cry = 1'b1; f_val = 3'd4;
        cyc(exp_obs(ROCK, NONE), "abort_start");
        start = 1'b0;
        cyc(exp_obs(WAIT, FU), "abort_pulse");
        cry = 1'b0;
        cyc(exp_obs(WAIT, NONE), "abort_wait");
        stop = 1'b1;
        cyc(exp_obs(IDLE, NONE), "stop_wait");
        stop = 1'b0; start = 1'b1;
        cyc(exp_obs(ROCK, NONE), "rock_before_reset");
        start = 1'b0;
        reset = 1'b1;
        #1;
        check(obs, exp_obs(IDLE, NONE), "async_reset_rock");
        #2;
        reset = 1'b0;
        start = 1'b1; cry = 1'b1;
        cyc(exp_obs(ROCK, NONE), "rock_again");
        start = 1'b0;
        cyc(exp_obs(WAIT, FU), "pulse_before_reset");
        reset = 1'b1;
        #1;
        check(obs, exp_obs(IDLE, NONE), "async_reset_pulse");
        #2;
        reset = 1'b0; cry = 1'b0;
        cyc(exp_obs(IDLE, NONE), "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
